// File: rtl/retire_trace_monitor.sv
// Retirement trace monitor: queues GRF writebacks and DM stores and streams them out valid/ready.
// Optional `TRACE_DISPLAY_EN prints each popped/dropped event (simulation only).
module retire_trace_monitor #(
    parameter int unsigned DEPTH      = 16,
    parameter logic [31:0] PC_LIMIT   = 32'h0000_4000,
    parameter int unsigned LOOP_LIMIT = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc_f,
    input  logic        grf_we,
    input  logic [31:0] grf_pc,
    input  logic [4:0]  grf_addr,
    input  logic [31:0] grf_data,
    input  logic        dm_we,
    input  logic [31:0] dm_pc,
    input  logic [31:0] dm_addr,
    input  logic [31:0] dm_data,
    output logic        trace_valid,
    input  logic        trace_ready,
    output logic        trace_kind,
    output logic [31:0] trace_pc,
    output logic [31:0] trace_addr,
    output logic [31:0] trace_data,
    output logic [15:0] drop_cnt,
    output logic        halt
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = $clog2(LOOP_LIMIT + 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
    state_t state, state_next;

    logic [DEPTH-1:0] mem_kind;
    logic [31:0]      mem_pc   [DEPTH];
    logic [31:0]      mem_addr [DEPTH];
    logic [31:0]      mem_data [DEPTH];

    logic [AW-1:0] wr_ptr, rd_ptr, dm_slot;
    logic [AW:0]   count, count_after_pop, free, count_next;
    logic [2:0]    flush_cnt;
    logic [31:0]   prev_pc;
    logic [LW-1:0] loop_cnt, run_len;
    logic          capture, ev_g, ev_d, push_g, push_d, pop, end_det;
    logic [1:0]    drop_n;
    logic [16:0]   drop_sum;

    always_comb begin
        capture = (state == IDLE) || (state == RUN) || (state == DRAIN && flush_cnt != 3'd0);
        ev_g    = capture && grf_we && (grf_addr != '0);
        ev_d    = capture && dm_we;

        trace_valid     = (count != '0) && (state != DONE);
        pop             = trace_valid && trace_ready;
        count_after_pop = count - {{AW{1'b0}}, pop};
        free            = (AW+1)'(DEPTH) - count_after_pop;

        // GRF claims the first free slot; DM needs one more slot beyond whatever GRF took
        push_g = ev_g && (free != '0);
        push_d = ev_d && (free > {{AW{1'b0}}, push_g});
        drop_n = {1'b0, ev_g && !push_g} + {1'b0, ev_d && !push_d};

        dm_slot    = wr_ptr + {{(AW-1){1'b0}}, push_g};
        count_next = count_after_pop + {{AW{1'b0}}, push_g} + {{AW{1'b0}}, push_d};
        drop_sum   = {1'b0, drop_cnt} + {15'd0, drop_n};

        trace_kind = trace_valid ? mem_kind[rd_ptr] : 1'b0;
        trace_pc   = trace_valid ? mem_pc[rd_ptr]   : '0;
        trace_addr = trace_valid ? mem_addr[rd_ptr] : '0;
        trace_data = trace_valid ? mem_data[rd_ptr] : '0;
        halt       = (state == DONE);
    end

    // run_len counts the current cycle, so LOOP_LIMIT identical samples trigger on the last one
    always_comb begin
        if (pc_f != prev_pc)
            run_len = LW'(1);
        else if (loop_cnt >= LW'(LOOP_LIMIT))
            run_len = loop_cnt;
        else
            run_len = loop_cnt + LW'(1);
        end_det = (pc_f >= PC_LIMIT) || (run_len >= LW'(LOOP_LIMIT));
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    state_next = RUN;
            RUN:     if (end_det) state_next = DRAIN;
            DRAIN:   if (flush_cnt == 3'd0 && count == '0) state_next = DONE;
            DONE:    state_next = DONE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            drop_cnt  <= '0;
            flush_cnt <= '0;
            prev_pc   <= '0;
            loop_cnt  <= '0;
        end else begin
            state    <= state_next;
            wr_ptr   <= wr_ptr + {{(AW-1){1'b0}}, push_g} + {{(AW-1){1'b0}}, push_d};
            rd_ptr   <= rd_ptr + {{(AW-1){1'b0}}, pop};
            count    <= count_next;
            drop_cnt <= drop_sum[16] ? '1 : drop_sum[15:0];
            if (state == RUN && state_next == DRAIN)
                flush_cnt <= 3'd4;
            else if (state == DRAIN && flush_cnt != 3'd0)
                flush_cnt <= flush_cnt - 3'd1;
            if (state != DONE) begin
                prev_pc  <= pc_f;
                loop_cnt <= run_len;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push_g) begin
            mem_kind[wr_ptr] <= 1'b0;
            mem_pc[wr_ptr]   <= grf_pc;
            mem_addr[wr_ptr] <= {27'd0, grf_addr};
            mem_data[wr_ptr] <= grf_data;
        end
        if (push_d) begin
            mem_kind[dm_slot] <= 1'b1;
            mem_pc[dm_slot]   <= dm_pc;
            mem_addr[dm_slot] <= dm_addr;
            mem_data[dm_slot] <= dm_data;
        end
    end

`ifdef TRACE_DISPLAY_EN
    always_ff @(posedge clk) begin
        if (reset && pop) begin
            if (trace_kind)
                $display("@%h: *%h <= %h", trace_pc, trace_addr, trace_data);
            else
                $display("@%h: $%d <= %h", trace_pc, trace_addr[4:0], trace_data);
        end
        if (reset && ev_g && !push_g) $display("TRACE DROP @%h", grf_pc);
        if (reset && ev_d && !push_d) $display("TRACE DROP @%h", dm_pc);
    end
`else
    // synthesizable build: trace printing compiled out
`endif

endmodule

// File: tb/tb_retire_trace_monitor.sv
// Scoreboard bench for retire_trace_monitor: directed events push expected entries,
// a negedge monitor pops and compares every accepted trace beat.
module tb_retire_trace_monitor;
    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc_f;
    logic        grf_we;
    logic [31:0] grf_pc;
    logic [4:0]  grf_addr;
    logic [31:0] grf_data;
    logic        dm_we;
    logic [31:0] dm_pc, dm_addr, dm_data;
    logic        trace_valid, trace_ready, trace_kind;
    logic [31:0] trace_pc, trace_addr, trace_data;
    logic [15:0] drop_cnt;
    logic        halt;

    typedef struct packed {
        logic        kind;
        logic [31:0] pc;
        logic [31:0] addr;
        logic [31:0] data;
    } ent_t;

    ent_t sb[$];
    ent_t mon_e;
    int   tests = 0;
    int   fails = 0;
    bit   pc_hold = 1'b0;

    retire_trace_monitor #(
        .DEPTH(16),
        .PC_LIMIT(32'h0000_4000),
        .LOOP_LIMIT(8)
    ) dut (
        .clk(clk), .reset(reset), .pc_f(pc_f),
        .grf_we(grf_we), .grf_pc(grf_pc), .grf_addr(grf_addr), .grf_data(grf_data),
        .dm_we(dm_we), .dm_pc(dm_pc), .dm_addr(dm_addr), .dm_data(dm_data),
        .trace_valid(trace_valid), .trace_ready(trace_ready), .trace_kind(trace_kind),
        .trace_pc(trace_pc), .trace_addr(trace_addr), .trace_data(trace_data),
        .drop_cnt(drop_cnt), .halt(halt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (reset === 1'b1 && trace_valid === 1'b1 && trace_ready === 1'b1) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL pop_unexpected: got pc %h addr %h data %h, expected no entry",
                         trace_pc, trace_addr, trace_data);
            end else begin
                mon_e = sb.pop_front();
                chk("pop_kind", 32'(trace_kind), 32'(mon_e.kind));
                chk("pop_pc",   trace_pc,   mon_e.pc);
                chk("pop_addr", trace_addr, mon_e.addr);
                chk("pop_data", trace_data, mon_e.data);
            end
        end
    end

    // fetch PC advances every cycle inside 0x1000..0x1FFF unless held
    task automatic step();
        @(posedge clk);
        #1;
        if (!pc_hold) pc_f = 32'h1000 | ((pc_f + 32'd4) & 32'h0000_0FFF);
    endtask

    task automatic send(input bit g, input logic [4:0] ga, input logic [31:0] gd,
                        input bit d, input logic [31:0] da, input logic [31:0] dd,
                        input logic [31:0] ipc, input bit exp_g, input bit exp_d);
        grf_we = g; grf_addr = ga; grf_data = gd; grf_pc = ipc;
        dm_we = d;  dm_addr = da;  dm_data = dd;  dm_pc = ipc + 32'd4;
        if (exp_g) sb.push_back('{kind: 1'b0, pc: ipc, addr: {27'd0, ga}, data: gd});
        if (exp_d) sb.push_back('{kind: 1'b1, pc: ipc + 32'd4, addr: da, data: dd});
        step();
        grf_we = 1'b0;
        dm_we  = 1'b0;
    endtask

    task automatic wait_empty(input string name, input int budget);
        int n = 0;
        while (trace_valid === 1'b1 && n < budget) begin
            step();
            n++;
        end
        chk(name, 32'(trace_valid), 32'd0);
        chk({name, "_sb"}, sb.size(), 32'd0);
    endtask

    task automatic wait_halt(input string name, input int budget);
        int n = 0;
        while (halt !== 1'b1 && n < budget) begin
            step();
            n++;
        end
        chk(name, 32'(halt), 32'd1);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        step();
        step();
        reset = 1'b1;
        step();
        step();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0; pc_f = 32'h1000; trace_ready = 1'b0;
        grf_we = 1'b0; grf_addr = '0; grf_data = '0; grf_pc = '0;
        dm_we = 1'b0; dm_pc = '0; dm_addr = '0; dm_data = '0;
        #12;
        chk("rst_valid", 32'(trace_valid), 32'd0);
        chk("rst_kind",  32'(trace_kind), 32'd0);
        chk("rst_pc",    trace_pc, 32'd0);
        chk("rst_addr",  trace_addr, 32'd0);
        chk("rst_data",  trace_data, 32'd0);
        chk("rst_drop",  32'(drop_cnt), 32'd0);
        chk("rst_halt",  32'(halt), 32'd0);
        #3 reset = 1'b1;
        step();
        step();

        // 1: single GRF writeback
        trace_ready = 1'b1;
        send(1, 5'd5, 32'h1234, 0, '0, '0, 32'h3000, 1, 0);
        chk("t1_valid", 32'(trace_valid), 32'd1);
        chk("t1_kind",  32'(trace_kind), 32'd0);
        chk("t1_addr",  trace_addr, 32'd5);
        chk("t1_data",  trace_data, 32'h1234);
        chk("t1_pc",    trace_pc, 32'h3000);

        // 2: writes to $0 are not traced
        send(1, 5'd0, 32'hDEAD, 0, '0, '0, pc_f, 0, 0);
        chk("t2_valid", 32'(trace_valid), 32'd0);
        step();
        chk("t2_valid_hold", 32'(trace_valid), 32'd0);

        // 3: simultaneous GRF + DM, GRF first
        trace_ready = 1'b0;
        send(1, 5'd7, 32'hAAAA, 1, 32'h100, 32'hBBBB, 32'h3004, 1, 1);
        chk("t3_head_kind", 32'(trace_kind), 32'd0);
        chk("t3_head_addr", trace_addr, 32'd7);
        step();
        chk("t3_held_valid", 32'(trace_valid), 32'd1);
        trace_ready = 1'b1;
        step();
        chk("t3_second_kind", 32'(trace_kind), 32'd1);
        chk("t3_second_addr", trace_addr, 32'h100);
        step();
        chk("t3_empty", 32'(trace_valid), 32'd0);

        // 4: overflow with 20 events into 16 slots
        trace_ready = 1'b0;
        for (int i = 0; i < 20; i++)
            send(1, 5'(i % 31 + 1), 32'hA000 + 32'(i), 0, '0, '0, pc_f, i < 16, 0);
        chk("t4_drop", 32'(drop_cnt), 32'd4);
        chk("t4_valid", 32'(trace_valid), 32'd1);
        chk("t4_head_data", trace_data, 32'hA000);
        trace_ready = 1'b1;
        send(1, 5'd9, 32'hF00D, 0, '0, '0, pc_f, 1, 0);
        chk("t4_full_pushpop_drop", 32'(drop_cnt), 32'd4);
        wait_empty("t4_drain", 40);
        chk("t4_drop_after", 32'(drop_cnt), 32'd4);

        // 4c: one free slot with GRF + DM, then DM into a full FIFO
        trace_ready = 1'b0;
        for (int i = 0; i < 15; i++)
            send(1, 5'd2, 32'hB000 + 32'(i), 0, '0, '0, pc_f, 1, 0);
        send(1, 5'd3, 32'hC3, 1, 32'h200, 32'hD3, pc_f, 1, 0);
        chk("t4c_drop_dm", 32'(drop_cnt), 32'd5);
        send(0, 5'd0, '0, 1, 32'h204, 32'hD4, pc_f, 0, 0);
        chk("t4c_drop_full", 32'(drop_cnt), 32'd6);
        trace_ready = 1'b1;
        wait_empty("t4c_drain", 40);

        // 5: PC limit with 3 queued entries
        trace_ready = 1'b0;
        for (int i = 0; i < 3; i++)
            send(1, 5'(20 + i), 32'hE000 + 32'(i), 0, '0, '0, pc_f, 1, 0);
        pc_f = 32'h4000;
        pc_hold = 1'b1;
        step();
        chk("t5_halt_e0", 32'(halt), 32'd0);
        trace_ready = 1'b1;
        pc_hold = 1'b0;
        send(1, 5'd11, 32'h5555, 0, '0, '0, pc_f, 1, 0);
        chk("t5_halt_e1", 32'(halt), 32'd0);
        step();
        step();
        chk("t5_halt_e3", 32'(halt), 32'd0);
        step();
        send(1, 5'd12, 32'h6666, 0, '0, '0, pc_f, 0, 0);
        wait_halt("t5_halt", 20);
        chk("t5_sb_empty", sb.size(), 32'd0);
        send(1, 5'd13, 32'h7777, 1, 32'h300, 32'h8888, pc_f, 0, 0);
        chk("t5_done_valid", 32'(trace_valid), 32'd0);
        step();
        step();
        step();
        chk("t5_halt_sticky", 32'(halt), 32'd1);

        // 6a: PC held 7 cycles does not end the program
        #2 reset = 1'b0;
        #1 chk("t6_rst_halt", 32'(halt), 32'd0);
        step();
        reset = 1'b1;
        step();
        step();
        pc_f = 32'h3010;
        pc_hold = 1'b1;
        repeat (7) step();
        pc_f = 32'h3020;
        pc_hold = 1'b0;
        repeat (15) step();
        chk("t6a_nohalt", 32'(halt), 32'd0);
        trace_ready = 1'b1;
        send(1, 5'd4, 32'h7777, 0, '0, '0, pc_f, 1, 0);
        wait_empty("t6a_still_run", 10);

        // 6b: PC held 8 cycles ends the program
        pc_f = 32'h3010;
        pc_hold = 1'b1;
        repeat (8) step();
        pc_hold = 1'b0;
        chk("t6b_halt_drain", 32'(halt), 32'd0);
        wait_halt("t6b_halt", 20);

        // 6c: drop counter saturation
        do_reset();
        trace_ready = 1'b0;
        for (int i = 0; i < 16; i++)
            send(1, 5'd6, 32'h9000 + 32'(i), 0, '0, '0, pc_f, 1, 0);
        for (int i = 0; i < 32767; i++)
            send(1, 5'd1, 32'h1, 1, 32'h400, 32'h2, pc_f, 0, 0);
        chk("t6c_drop_fffe", 32'(drop_cnt), 32'h0000_FFFE);
        send(0, 5'd0, '0, 1, 32'h404, 32'h3, pc_f, 0, 0);
        chk("t6c_drop_ffff", 32'(drop_cnt), 32'h0000_FFFF);
        send(1, 5'd1, 32'h1, 1, 32'h408, 32'h4, pc_f, 0, 0);
        chk("t6c_drop_sat", 32'(drop_cnt), 32'h0000_FFFF);

        // 6d: reset during DRAIN with queued entries
        pc_f = 32'h3010;
        pc_hold = 1'b1;
        repeat (8) step();
        step();
        chk("t6d_pre_valid", 32'(trace_valid), 32'd1);
        chk("t6d_pre_halt", 32'(halt), 32'd0);
        #3 reset = 1'b0;
        #1;
        chk("t6d_valid", 32'(trace_valid), 32'd0);
        chk("t6d_kind",  32'(trace_kind), 32'd0);
        chk("t6d_pc",    trace_pc, 32'd0);
        chk("t6d_addr",  trace_addr, 32'd0);
        chk("t6d_data",  trace_data, 32'd0);
        chk("t6d_drop",  32'(drop_cnt), 32'd0);
        chk("t6d_halt",  32'(halt), 32'd0);
        sb.delete();
        pc_hold = 1'b0;
        step();
        step();
        reset = 1'b1;
        step();
        step();
        chk("t6d_post_valid", 32'(trace_valid), 32'd0);
        chk("t6d_post_drop", 32'(drop_cnt), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
